// File: rtl/mem_arbiter_seq_if.sv
// Bus between mem_arbiter_seq, its three requesters and main memory.
//   Requester side : reqI/reqAddrI (I-fill), reqD/reqAddrD (D-fill),
//                    reqW/writeAddr/writeData (write-back),
//                    rdata, doneI/doneD/doneW, busy
//   Memory side    : mem_en, mem_op, mem_index, mem_wdata, mem_rdata
// Modports: slave = arbiter, master = requesters + memory model.
interface mem_arbiter_seq_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              reqI;
    logic [ADDR_W-1:0] reqAddrI;
    logic              reqD;
    logic [ADDR_W-1:0] reqAddrD;
    logic              reqW;
    logic [ADDR_W-1:0] writeAddr;
    logic [LINE_W-1:0] writeData;
    logic              mem_en;
    logic [1:0]        mem_op;
    logic [ADDR_W-5:0] mem_index;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic [LINE_W-1:0] rdata;
    logic              doneI;
    logic              doneD;
    logic              doneW;
    logic              busy;

    modport slave (
        input  reqI, reqAddrI, reqD, reqAddrD, reqW, writeAddr, writeData, mem_rdata,
        output mem_en, mem_op, mem_index, mem_wdata, rdata, doneI, doneD, doneW, busy
    );

    modport master (
        output reqI, reqAddrI, reqD, reqAddrD, reqW, writeAddr, writeData, mem_rdata,
        input  mem_en, mem_op, mem_index, mem_wdata, rdata, doneI, doneD, doneW, busy
    );
endinterface

// File: rtl/mem_arbiter_seq.sv
// mem_arbiter_seq: shares one line-wide memory port between I-fill, D-fill
// and D write-back. One transaction at a time: grant in IDLE, hold the
// memory for MEM_LATENCY cycles (BUSY), then one RESP cycle with a done
// pulse and the registered read line.
//
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_arbiter_seq_if.slave (request, response and memory signals)
//
// Optional: define ARB_STARVE_GUARD_EN to promote I after STARVE_LIMIT
// consecutive lost arbitrations; otherwise strict priority W > D > I.
module mem_arbiter_seq #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 128,
    parameter int MEM_LATENCY  = 10,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_arbiter_seq_if.slave  bus
);
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_INST  = 2'd1;
    localparam logic [1:0] OP_DATA  = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt;
    logic [1:0]        grant_op;
    logic [ADDR_W-1:0] grant_addr;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] age;
    logic       promote_i;
    assign promote_i = bus.reqI && (int'(age) >= STARVE_LIMIT);
`endif

    // Line offset bits never reach memory; STARVE_LIMIT only matters with the guard.
    logic unused;
    assign unused = ^{grant_addr[3:0], 1'(STARVE_LIMIT)};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        grant_op   = OP_NONE;
        grant_addr = '0;
        case (state)
            IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
                if (promote_i) begin
                    grant_op = OP_INST; grant_addr = bus.reqAddrI;
                end else
`endif
                if (bus.reqW) begin
                    grant_op = OP_WRITE; grant_addr = bus.writeAddr;
                end else if (bus.reqD) begin
                    grant_op = OP_DATA; grant_addr = bus.reqAddrD;
                end else if (bus.reqI) begin
                    grant_op = OP_INST; grant_addr = bus.reqAddrI;
                end
                if (grant_op != OP_NONE) state_n = BUSY;
            end
            BUSY:    if (cnt == 8'd0) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // mem_op doubles as the owner record until the BUSY->RESP edge,
    // where it selects the done line and is then cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_op    <= OP_NONE;
            bus.mem_index <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
            bus.doneI     <= 1'b0;
            bus.doneD     <= 1'b0;
            bus.doneW     <= 1'b0;
        end else begin
            bus.mem_en <= 1'b0;
            bus.doneI  <= 1'b0;
            bus.doneD  <= 1'b0;
            bus.doneW  <= 1'b0;
            case (state)
                IDLE: if (grant_op != OP_NONE) begin
                    bus.mem_en    <= 1'b1;
                    bus.mem_op    <= grant_op;
                    bus.mem_index <= grant_addr[ADDR_W-1:4];
                    if (grant_op == OP_WRITE) bus.mem_wdata <= bus.writeData;
                    cnt <= 8'(MEM_LATENCY - 1);
                end
                BUSY: if (cnt == 8'd0) begin
                    bus.mem_op <= OP_NONE;
                    bus.doneI  <= (bus.mem_op == OP_INST);
                    bus.doneD  <= (bus.mem_op == OP_DATA);
                    bus.doneW  <= (bus.mem_op == OP_WRITE);
                    if (bus.mem_op != OP_WRITE) bus.rdata <= bus.mem_rdata;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Age counts grants that bypassed a waiting I; saturates at 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            age <= '0;
        end else if (state == IDLE && grant_op != OP_NONE) begin
            if (grant_op == OP_INST || !bus.reqI) age <= '0;
            else if (age != 3'd7)                 age <= age + 3'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter_seq.sv
// Directed bench for mem_arbiter_seq (MEM_LATENCY = 10). Memory read data
// is a free-running cycle stamp so the capture cycle of rdata is visible.
module tb_mem_arbiter_seq;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int L      = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_seq_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter_seq #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LATENCY(L), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.mem_rdata = {96'hC0DE_0000_BEEF_0000_FACE_0000, cyc[31:0]};

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},    LINE_W'(bus.mem_en), 0);
        chk({tag, "_op"},    LINE_W'(bus.mem_op), 0);
        chk({tag, "_idx"},   LINE_W'(bus.mem_index), 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_done"},  LINE_W'({bus.doneW, bus.doneD, bus.doneI}), 0);
        chk({tag, "_busy"},  LINE_W'(bus.busy), 0);
    endtask

    // Called in an IDLE cycle with requests already driven. Follows one
    // transaction to its done pulse and returns in the following IDLE cycle.
    task automatic serve(input string tag, input logic [1:0] op, input logic [ADDR_W-5:0] idx,
                         input logic [LINE_W-1:0] wdata, input bit drop, input bit chg_addr);
        logic [LINE_W-1:0] rd_prev, last_mrd;
        logic [2:0] exp_done;
        int n;
        bit seen;
        rd_prev  = bus.rdata;
        last_mrd = '0;
        exp_done = (op == 2'd3) ? 3'b100 : (op == 2'd2) ? 3'b010 : 3'b001;
        step();
        chk({tag, "_en1"},  LINE_W'(bus.mem_en), 1);
        chk({tag, "_op"},   LINE_W'(bus.mem_op), LINE_W'(op));
        chk({tag, "_idx"},  LINE_W'(bus.mem_index), LINE_W'(idx));
        chk({tag, "_busy"}, LINE_W'(bus.busy), 1);
        if (op == 2'd3) chk({tag, "_wdata"}, bus.mem_wdata, wdata);
        n = 1;
        seen = 0;
        while (!seen && n < 3 * L) begin
            if (chg_addr && n == 1) begin
                step();
                n++;
                bus.reqAddrD = 32'h300;
                chk({tag, "_idx_hold"}, LINE_W'(bus.mem_index), LINE_W'(idx));
            end
            last_mrd = bus.mem_rdata;
            step();
            n++;
            if (bus.doneI || bus.doneD || bus.doneW) seen = 1;
            else begin
                chk({tag, "_op_hold"},  LINE_W'(bus.mem_op), LINE_W'(op));
                chk({tag, "_idx_hold"}, LINE_W'(bus.mem_index), LINE_W'(idx));
                chk({tag, "_en_low"},   LINE_W'(bus.mem_en), 0);
            end
        end
        chk({tag, "_seen"},    LINE_W'(seen), 1);
        chk({tag, "_latency"}, LINE_W'(n), LINE_W'(L + 1));
        chk({tag, "_done"},    LINE_W'({bus.doneW, bus.doneD, bus.doneI}), LINE_W'(exp_done));
        chk({tag, "_resp_op"}, LINE_W'(bus.mem_op), 0);
        chk({tag, "_rdata"},   bus.rdata, (op == 2'd3) ? rd_prev : last_mrd);
        if (drop) begin
            if (op == 2'd3) bus.reqW = 1'b0;
            else if (op == 2'd2) bus.reqD = 1'b0;
            else bus.reqI = 1'b0;
        end
        step();
        chk({tag, "_pulse1"}, LINE_W'({bus.doneW, bus.doneD, bus.doneI}), 0);
        chk({tag, "_idle"},   LINE_W'(bus.busy), 0);
    endtask

    initial begin
        int t0;
        bus.reqI = 0; bus.reqD = 0; bus.reqW = 0;
        bus.reqAddrI = '0; bus.reqAddrD = '0; bus.writeAddr = '0; bus.writeData = '0;

        step(); step();
        chk_zero("rst");
        reset = 1'b0;
        step();
        chk("idle_busy", LINE_W'(bus.busy), 0);

        // Single I read, address 0x40 -> index 0x4
        bus.reqI = 1; bus.reqAddrI = 32'h40;
        serve("i_read", 2'd1, 28'h4, '0, 1, 0);

        // All three at once: W, then D, then I, 12 cycles apart
        bus.reqW = 1; bus.writeAddr = 32'h100; bus.writeData = {4{32'h1234_5678}};
        bus.reqD = 1; bus.reqAddrD = 32'h200;
        bus.reqI = 1; bus.reqAddrI = 32'h330;
        serve("pri_w", 2'd3, 28'h10, {4{32'h1234_5678}}, 1, 0);
        t0 = cyc;
        serve("pri_d", 2'd2, 28'h20, '0, 1, 0);
        chk("pri_gap_wd", LINE_W'(cyc - t0), LINE_W'(L + 2));
        t0 = cyc;
        serve("pri_i", 2'd1, 28'h33, '0, 1, 0);
        chk("pri_gap_di", LINE_W'(cyc - t0), LINE_W'(L + 2));

        // Write-back: rdata must keep the last read line
        bus.reqW = 1; bus.writeAddr = 32'h100; bus.writeData = {16{8'hA5}};
        serve("wr", 2'd3, 28'h10, {16{8'hA5}}, 1, 0);

        // Address change mid-transaction is ignored
        bus.reqD = 1; bus.reqAddrD = 32'h200;
        serve("addr_chg", 2'd2, 28'h20, '0, 1, 1);

        // Reset in the 5th BUSY cycle of a D read
        bus.reqD = 1; bus.reqAddrD = 32'h200;
        for (int k = 0; k < 5; k++) step();
        chk("rst_mid_busy", LINE_W'(bus.busy), 1);
        reset = 1'b1;
        bus.reqD = 0;
        step();
        chk_zero("rst_mid");
        reset = 1'b0;
        for (int k = 0; k < L + 3; k++) begin
            step();
            chk("rst_no_done", LINE_W'({bus.doneW, bus.doneD, bus.doneI}), 0);
        end
        bus.reqI = 1; bus.reqAddrI = 32'h40;
        serve("post_rst_i", 2'd1, 28'h4, '0, 1, 0);

        // D held continuously alongside I
        bus.reqD = 1; bus.reqAddrD = 32'h500;
        bus.reqI = 1; bus.reqAddrI = 32'h600;
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) serve("starve_d", 2'd2, 28'h50, '0, 0, 0);
        serve("starve_i", 2'd1, 28'h60, '0, 1, 0);
        serve("starve_d_resume", 2'd2, 28'h50, '0, 1, 0);
`else
        for (int k = 0; k < 5; k++) serve("starve_d", 2'd2, 28'h50, '0, 0, 0);
        serve("starve_d_last", 2'd2, 28'h50, '0, 1, 0);
        serve("starve_i_late", 2'd1, 28'h60, '0, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
